// File: rtl/pe_conv_mac_accum_conv1_pkg.sv
`default_nettype none
// ============================================================================
// conv1_mac_pkg : widths and index helpers shared by the conv1 MAC slice
// Rev 1.0
// ============================================================================
package conv1_mac_pkg;

    function automatic int calc_acc_w(input int dw, input int ww, input int k, input int ip);
        return dw + ww + $clog2(k * k * ip) + 1;
    endfunction

    function automatic int calc_k2(input int k);
        return k * k;
    endfunction

    // Sign-extend the low w bits of v to 64 bits
    function automatic logic [63:0] sext64(input logic [63:0] v, input int w);
        logic [63:0] sh;
        sh = v << (64 - w);
        return $unsigned($signed(sh) >>> (64 - w));
    endfunction

    function automatic int weight_lsb(input int o, input int i, input int ip, input int ww);
        return (o * ip + i) * ww;
    endfunction

    function automatic int dout_lsb(input int o, input int accw);
        return o * accw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_conv_mac_accum_conv1_lane.sv
`default_nettype none
// ============================================================================
// pe_conv_mac_lane : one output channel - lane MAC, accumulator, result reg
// Rev 1.0
// ============================================================================
module pe_conv_mac_lane
    import conv1_mac_pkg::*;
#(
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int BW    = 16,
    parameter int IP    = 1,
    parameter int ACC_W = 21
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 beat_i,
    input  logic                 last_i,
    input  logic                 s2_valid_i,
    input  logic                 s2_last_i,
    input  logic                 load_i,
    input  logic [DW*IP-1:0]     data_i,
    input  logic [WW*IP-1:0]     weight_i,
    input  logic [BW-1:0]        bias_i,
    output logic [ACC_W-1:0]     result_o
);
    localparam int PW = DW + WW;

    logic signed [PW-1:0] prod_raw;
    logic [63:0]          prod_ext;
    logic [63:0]          bias_ext;
    logic [ACC_W-1:0]     sum_d;
    logic [ACC_W-1:0]     acc_d;
    logic [ACC_W-1:0]     result_d;
    logic [ACC_W-1:0]     prod_q;
    logic [ACC_W-1:0]     acc_q;
    logic [ACC_W-1:0]     result_q;
    logic [BW-1:0]        bias_q;

    always_comb begin
        sum_d    = '0;
        prod_raw = '0;
        prod_ext = '0;
        for (int i = 0; i < IP; i++) begin
            prod_raw = $signed(data_i[i*DW +: DW]) * $signed(weight_i[i*WW +: WW]);
            prod_ext = sext64({{(64-PW){1'b0}}, prod_raw}, PW);
            sum_d    = sum_d + prod_ext[ACC_W-1:0];
        end
    end

    always_comb begin
        bias_ext = sext64({{(64-BW){1'b0}}, bias_q}, BW);
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (s2_valid_i) begin
            acc_d = s2_last_i ? '0 : acc_q + prod_q;
        end
        result_d = acc_q + prod_q + bias_ext[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q   <= '0;
            bias_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            if (beat_i) begin
                prod_q <= sum_d;
            end
            if (beat_i && last_i) begin
                bias_q <= bias_i;
            end
            acc_q <= acc_d;
            if (load_i) begin
                result_q <= result_d;
            end
        end
    end

    assign result_o = result_q;

endmodule
`default_nettype wire

// File: rtl/pe_conv_mac_accum_conv1.sv
`default_nettype none
// ============================================================================
// pe_conv_mac_accum_conv1 : conv1 window MAC with bias and valid/ready output
// Rev 1.0
// ============================================================================
module pe_conv_mac_accum_conv1
    import conv1_mac_pkg::*;
#(
    parameter int pDATA_WIDTH      = 8,
    parameter int pWEIGHT_WIDTH    = 8,
    parameter int pBIAS_WIDTH      = 16,
    parameter int pKERNEL_SIZE     = 3,
    parameter int pINPUT_PARALLEL  = 1,
    parameter int pOUTPUT_PARALLEL = 4,
    localparam int ACC_W = calc_acc_w(pDATA_WIDTH, pWEIGHT_WIDTH, pKERNEL_SIZE, pINPUT_PARALLEL)
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 clr,
    input  logic                                                 valid_in,
    input  logic [pDATA_WIDTH*pINPUT_PARALLEL-1:0]               data_in,
    input  logic [pWEIGHT_WIDTH*pINPUT_PARALLEL*pOUTPUT_PARALLEL-1:0] weight_in,
    input  logic [pBIAS_WIDTH*pOUTPUT_PARALLEL-1:0]              bias_in,
    output logic [ACC_W*pOUTPUT_PARALLEL-1:0]                    data_out,
    output logic                                                 valid_out,
    input  logic                                                 ready_out,
    output logic                                                 overflow
);
    localparam int K2    = calc_k2(pKERNEL_SIZE);
    localparam int CNT_W = $clog2(K2 + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             s1_valid_q;
    logic             s1_last_q;
    logic             valid_out_q;
    logic             overflow_q;

    logic beat;
    logic last;
    logic s2_valid;
    logic load;
    logic load_ok;

    // clr kills both the incoming beat and the product already in stage 1
    assign beat     = valid_in & ~clr;
    assign last     = (cnt_q == CNT_W'(K2 - 1));
    assign s2_valid = s1_valid_q & ~clr;
    assign load     = s2_valid & s1_last_q;
    assign load_ok  = load & (~valid_out_q | ready_out);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (clr) begin
                cnt_q <= '0;
            end else if (valid_in) begin
                cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
            end
            s1_valid_q <= beat;
            s1_last_q  <= beat & last;
            if (load_ok) begin
                valid_out_q <= 1'b1;
            end else if (ready_out) begin
                valid_out_q <= 1'b0;
            end
            if (load && !load_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign valid_out = valid_out_q;
    assign overflow  = overflow_q;

    for (genvar o = 0; o < pOUTPUT_PARALLEL; o++) begin : g_lane
        pe_conv_mac_lane #(
            .DW    (pDATA_WIDTH),
            .WW    (pWEIGHT_WIDTH),
            .BW    (pBIAS_WIDTH),
            .IP    (pINPUT_PARALLEL),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr),
            .beat_i     (beat),
            .last_i     (last),
            .s2_valid_i (s2_valid),
            .s2_last_i  (s1_last_q),
            .load_i     (load_ok),
            .data_i     (data_in),
            .weight_i   (weight_in[weight_lsb(o, 0, pINPUT_PARALLEL, pWEIGHT_WIDTH) +: pWEIGHT_WIDTH*pINPUT_PARALLEL]),
            .bias_i     (bias_in[o*pBIAS_WIDTH +: pBIAS_WIDTH]),
            .result_o   (data_out[dout_lsb(o, ACC_W) +: ACC_W])
        );
    end

endmodule
`default_nettype wire
